// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, control field codes, state codes.
// Pure declarations, no timing or flow control of their own.
package multicycle_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_JUMP   = 2'b01;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
    localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
    localparam logic [1:0] MEMTOREG_PC     = 2'b10;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTEXE  = 4'd7,
        S_RTWB   = 4'd8,
        S_BEQ    = 4'd9,
        S_JMP    = 4'd10,
        S_JAL    = 4'd11,
        S_ADDIEX = 4'd12,
        S_ANDIEX = 4'd13,
        S_IMMWB  = 4'd14,
        S_HALT   = 4'd15
    } state_t;

    // Full datapath control word, one field per strobe.
    typedef struct packed {
        logic       alusrca;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       pcwritecond;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
            OP_J, OP_JAL, OP_ADDI, OP_ANDI: is_legal_op = 1'b1;
            default:                        is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the control FSM (master) and the datapath (slave); CTRL_ILLEGAL_TRAP_EN adds illegal_op.
// Wires only: every strobe is a level valid for the whole cycle, no handshake.
interface multicycle_ctrl_if;

    logic [5:0] opcode;
    logic       ALUSrcA;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCWriteCond;
    logic [1:0] PCSrc;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [3:0] state_o;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal_op;

    modport master (
        input  opcode,
        output ALUSrcA, memread, memwrite, regwrite, IorD, IRWrite,
               PCWrite, PCWriteCond, PCSrc, ALUSrcB, ALUOp, regdst,
               memtoreg, state_o, illegal_op
    );

    modport slave (
        output opcode,
        input  ALUSrcA, memread, memwrite, regwrite, IorD, IRWrite,
               PCWrite, PCWriteCond, PCSrc, ALUSrcB, ALUOp, regdst,
               memtoreg, state_o, illegal_op
    );
`else
    modport master (
        input  opcode,
        output ALUSrcA, memread, memwrite, regwrite, IorD, IRWrite,
               PCWrite, PCWriteCond, PCSrc, ALUSrcB, ALUOp, regdst,
               memtoreg, state_o
    );

    modport slave (
        output opcode,
        input  ALUSrcA, memread, memwrite, regwrite, IorD, IRWrite,
               PCWrite, PCWriteCond, PCSrc, ALUSrcB, ALUOp, regdst,
               memtoreg, state_o
    );
`endif

endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS core; CTRL_ILLEGAL_TRAP_EN traps unknown opcodes into S_HALT.
// Strobes are a pure decode of the state register (CPI 3-5), no backpressure; rst aborts instantly.
module multicycle_ctrl
    import multicycle_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    multicycle_ctrl_if.master bus
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:    state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (!is_legal_op(bus.opcode)) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_nxt = S_HALT;
`else
                    state_nxt = S_FETCH;
`endif
                end else begin
                    case (bus.opcode)
                        OP_LW, OP_SW: state_nxt = S_MEMADR;
                        OP_RTYPE:     state_nxt = S_RTEXE;
                        OP_BEQ:       state_nxt = S_BEQ;
                        OP_J:         state_nxt = S_JMP;
                        OP_JAL:       state_nxt = S_JAL;
                        OP_ADDI:      state_nxt = S_ADDIEX;
                        OP_ANDI:      state_nxt = S_ANDIEX;
                        default:      state_nxt = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_nxt = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nxt = S_MEMWB;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  state_nxt = S_FETCH;
            S_RTEXE:  state_nxt = S_RTWB;
            S_RTWB:   state_nxt = S_FETCH;
            S_BEQ:    state_nxt = S_FETCH;
            S_JMP:    state_nxt = S_FETCH;
            S_JAL:    state_nxt = S_FETCH;
            S_ADDIEX: state_nxt = S_IMMWB;
            S_ANDIEX: state_nxt = S_IMMWB;
            S_IMMWB:  state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_RST;
        endcase
    end

    always_comb begin
        ctrl          = '0;
        ctrl.pcsrc    = PCSRC_ALU;
        ctrl.alusrcb  = SRCB_B;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.regdst   = REGDST_RT;
        ctrl.memtoreg = MEMTOREG_ALUOUT;
        case (state)
            S_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.irwrite = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.pcwrite = 1'b1;
            end
            // Branch target is computed speculatively while the opcode decodes.
            S_DECODE: ctrl.alusrcb = SRCB_BOFF;
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = MEMTOREG_MDR;
            end
            S_MEMWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_RTEXE: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = REGDST_RD;
            end
            S_BEQ: begin
                ctrl.alusrca     = 1'b1;
                ctrl.aluop       = ALUOP_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsrc       = PCSRC_ALUOUT;
            end
            S_JMP: begin
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = PCSRC_JUMP;
            end
            // Link register captures PC+4 on the same edge the PC takes the target.
            S_JAL: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsrc    = PCSRC_JUMP;
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = REGDST_R31;
                ctrl.memtoreg = MEMTOREG_PC;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_ANDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_AND;
            end
            S_IMMWB: ctrl.regwrite = 1'b1;
            default: ;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (state == S_DECODE && !is_legal_op(bus.opcode)) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.illegal_op = illegal_q;
`endif

    assign bus.ALUSrcA     = ctrl.alusrca;
    assign bus.memread     = ctrl.memread;
    assign bus.memwrite    = ctrl.memwrite;
    assign bus.regwrite    = ctrl.regwrite;
    assign bus.IorD        = ctrl.iord;
    assign bus.IRWrite     = ctrl.irwrite;
    assign bus.PCWrite     = ctrl.pcwrite;
    assign bus.PCWriteCond = ctrl.pcwritecond;
    assign bus.PCSrc       = ctrl.pcsrc;
    assign bus.ALUSrcB     = ctrl.alusrcb;
    assign bus.ALUOp       = ctrl.aluop;
    assign bus.regdst      = ctrl.regdst;
    assign bus.memtoreg    = ctrl.memtoreg;
    assign bus.state_o     = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction state traces and control words from a spec-level model.
// Works with or without CTRL_ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   exp_seq[$];

    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Order: ALUSrcA memread memwrite regwrite IorD IRWrite PCWrite PCWriteCond PCSrc ALUSrcB ALUOp regdst memtoreg
    function automatic logic [17:0] obs_ctrl();
        return {bus.ALUSrcA, bus.memread, bus.memwrite, bus.regwrite, bus.IorD,
                bus.IRWrite, bus.PCWrite, bus.PCWriteCond, bus.PCSrc, bus.ALUSrcB,
                bus.ALUOp, bus.regdst, bus.memtoreg};
    endfunction

    // Control word each state must present, straight from the state table.
    function automatic logic [17:0] exp_ctrl(input int s);
        logic a = 0, mr = 0, mw = 0, rw = 0, iod = 0, irw = 0, pcw = 0, pcc = 0;
        logic [1:0] pcs = 0, sb = 0, op = 0, rd = 0, mt = 0;
        case (s)
            1:  begin mr = 1; irw = 1; sb = 2'd1; pcw = 1; end
            2:  sb = 2'd3;
            3:  begin a = 1; sb = 2'd2; end
            4:  begin mr = 1; iod = 1; end
            5:  begin rw = 1; mt = 2'd1; end
            6:  begin mw = 1; iod = 1; end
            7:  begin a = 1; op = 2'd2; end
            8:  begin rw = 1; rd = 2'd1; end
            9:  begin a = 1; op = 2'd1; pcc = 1; pcs = 2'd2; end
            10: begin pcw = 1; pcs = 2'd1; end
            11: begin pcw = 1; pcs = 2'd1; rw = 1; rd = 2'd2; mt = 2'd2; end
            12: begin a = 1; sb = 2'd2; end
            13: begin a = 1; sb = 2'd2; op = 2'd3; end
            14: rw = 1;
            default: ;
        endcase
        return {a, mr, mw, rw, iod, irw, pcw, pcc, pcs, sb, op, rd, mt};
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000010, 6'b000011, 6'b001000, 6'b001100};
    endfunction

    // Expected state trace from FETCH up to (not including) the next FETCH.
    task automatic build_seq(input logic [5:0] op);
        case (op)
            6'b100011: exp_seq = {1, 2, 3, 4, 5};
            6'b101011: exp_seq = {1, 2, 3, 6};
            6'b000000: exp_seq = {1, 2, 7, 8};
            6'b000100: exp_seq = {1, 2, 9};
            6'b000010: exp_seq = {1, 2, 10};
            6'b000011: exp_seq = {1, 2, 11};
            6'b001000: exp_seq = {1, 2, 12, 14};
            6'b001100: exp_seq = {1, 2, 13, 14};
            default:   exp_seq = {1, 2};
        endcase
    endtask

    function automatic logic [5:0] rand_illegal();
        logic [5:0] op = 6'b111111;
        repeat (200) begin
            if (!is_legal(op)) break;
            op = 6'($urandom);
        end
        return op;
    endfunction

    // Runs one instruction from S_FETCH; opcode carries junk outside the sampling states.
    task automatic test_instr(input logic [5:0] op, input string name);
        build_seq(op);
        foreach (exp_seq[i]) begin
            bus.opcode = (exp_seq[i] == 2 || exp_seq[i] == 3) ? op : 6'($urandom);
            tests++;
            if (bus.state_o !== 4'(exp_seq[i])) begin
                fails++;
                $display("FAIL %s state[%0d]: got %0d want %0d", name, i, bus.state_o, exp_seq[i]);
            end
            tests++;
            if (obs_ctrl() !== exp_ctrl(exp_seq[i])) begin
                fails++;
                $display("FAIL %s ctrl[%0d]: got %h want %h", name, i, obs_ctrl(), exp_ctrl(exp_seq[i]));
            end
            tick();
        end
        tests++;
        if (bus.state_o !== 4'd1) begin
            fails++;
            $display("FAIL %s cpi: got state %0d want 1 after %0d cycles", name, bus.state_o, exp_seq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.opcode = 6'b000000;
        tick();
        tick();
        tests++;
        if (bus.state_o !== 4'd0 || obs_ctrl() !== 18'd0) begin
            fails++;
            $display("FAIL reset_hold: got state %0d ctrl %h want 0 0", bus.state_o, obs_ctrl());
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        tests++;
        if (bus.illegal_op !== 1'b0) begin
            fails++;
            $display("FAIL reset_illegal: got %b want 0", bus.illegal_op);
        end
`endif
        rst = 1'b0;
        #1;
        tests++;
        if (bus.state_o !== 4'd0 || obs_ctrl() !== 18'd0) begin
            fails++;
            $display("FAIL reset_dead: got state %0d ctrl %h want 0 0", bus.state_o, obs_ctrl());
        end
        tick();
        tests++;
        if (bus.state_o !== 4'd1 || obs_ctrl() !== {1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 6'd0}) begin
            fails++;
            $display("FAIL reset_fetch: got state %0d ctrl %h want 1 %h",
                     bus.state_o, obs_ctrl(), {1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 6'd0});
        end
    endtask

    task automatic test_directed();
        test_instr(6'b100011, "lw");
        test_instr(6'b101011, "sw");
        test_instr(6'b000011, "jal");
        test_instr(6'b001100, "andi");
        test_instr(6'b000000, "rtype");
        test_instr(6'b000100, "beq");
        test_instr(6'b000010, "j");
        test_instr(6'b001000, "addi");
    endtask

    task automatic test_random();
        logic [5:0] ops [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                6'b000010, 6'b000011, 6'b001000, 6'b001100};
        logic [5:0] op;
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(7)];
`ifndef CTRL_ILLEGAL_TRAP_EN
            if ($urandom_range(4) == 0) op = rand_illegal();
`endif
            test_instr(op, "random");
        end
    endtask

    // Async reset while a write strobe is live: everything must drop before the next edge.
    task automatic test_midreset();
        logic [5:0] ops [3]   = '{6'b101011, 6'b100011, 6'b000011};
        int         steps [3] = '{3, 4, 2};
        for (int k = 0; k < 3; k++) begin
            bus.opcode = ops[k];
            repeat (steps[k]) tick();
            tests++;
            if (bus.memwrite === 1'b0 && bus.regwrite === 1'b0) begin
                fails++;
                $display("FAIL midreset_pre[%0d]: got memwrite %b regwrite %b want a write", k, bus.memwrite, bus.regwrite);
            end
            #2 rst = 1'b1;
            #1;
            tests++;
            if (bus.state_o !== 4'd0 || obs_ctrl() !== 18'd0) begin
                fails++;
                $display("FAIL midreset[%0d]: got state %0d ctrl %h want 0 0", k, bus.state_o, obs_ctrl());
            end
            @(negedge clk) rst = 1'b0;
            tick();
            tests++;
            if (bus.state_o !== 4'd1) begin
                fails++;
                $display("FAIL midreset_restart[%0d]: got %0d want 1", k, bus.state_o);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] op = rand_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
        bus.opcode = op;
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            bus.opcode = 6'($urandom);
            tests++;
            if (bus.state_o !== 4'd15 || bus.illegal_op !== 1'b1 || obs_ctrl() !== 18'd0) begin
                fails++;
                $display("FAIL illegal_halt[%0d]: got state %0d illegal %b ctrl %h want 15 1 0",
                         c, bus.state_o, bus.illegal_op, obs_ctrl());
            end
            tick();
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (bus.state_o !== 4'd0 || bus.illegal_op !== 1'b0) begin
            fails++;
            $display("FAIL illegal_clear: got state %0d illegal %b want 0 0", bus.state_o, bus.illegal_op);
        end
        @(negedge clk) rst = 1'b0;
        tick();
`else
        test_instr(op, "illegal_nop");
        test_instr(6'b111111, "illegal_3f");
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.opcode = 6'b000000;
        test_reset();
        test_directed();
        test_random();
        test_midreset();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore FSM control unit for the multicycle MIPS core. It consumes the 6-bit opcode from the datapath's instruction register and drives every datapath control strobe. It sequences fetch, decode, execute, memory and writeback cycles per instruction. It sits directly beside the datapath, and the top level wires it port-for-port to the datapath's control inputs.

Parameters:
- none. Opcodes, ALUOp codes and state codes are package constants.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- opcode  in  6  inst[31:26] from the datapath IR
- ALUSrcA  out  1  0=PC, 1=A
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- regwrite  out  1  register file write enable
- IorD  out  1  0=PC address, 1=ALUOut address
- IRWrite  out  1  IR load enable
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if zero
- PCSrc  out  2  00=ALUResult, 01=jump target, 10=ALUOut
- ALUSrcB  out  2  00=B, 01=4, 10=signext, 11=signext<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct decode, 11=and
- regdst  out  2  00=rt, 01=rd, 10=r31
- memtoreg  out  2  00=ALUOut, 01=MDR, 10=PC
- state_o  out  4  current state code, for debug

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset: state resets to S_RST (0). All outputs are pure Moore decode of the state, so every control output is 0 during and immediately after reset.
- S_RST always goes to S_FETCH. One dead cycle follows reset deassertion.
- Any output not listed for a state is 0.
- S_FETCH (1): memread=1, IRWrite=1, ALUSrcB=01, PCWrite=1. Next state is S_DECODE.
- S_DECODE (2): ALUSrcB=11 (ALUOut gets PC+4+off<<2). Next state by opcode:
  - 100011 or 101011 -> S_MEMADR
  - 000000 -> S_RTEXE
  - 000100 -> S_BEQ
  - 000010 -> S_JMP
  - 000011 -> S_JAL
  - 001000 -> S_ADDIEX
  - 001100 -> S_ANDIEX
  - any other opcode -> illegal handling (see Optional Feature)
- S_MEMADR (3): ALUSrcA=1, ALUSrcB=10. Next: S_MEMRD if opcode is lw, else S_MEMWR.
- S_MEMRD (4): memread=1, IorD=1. Next: S_MEMWB.
- S_MEMWB (5): regwrite=1, memtoreg=01. Next: S_FETCH.
- S_MEMWR (6): memwrite=1, IorD=1. Next: S_FETCH.
- S_RTEXE (7): ALUSrcA=1, ALUOp=10. Next: S_RTWB.
- S_RTWB (8): regwrite=1, regdst=01. Next: S_FETCH.
- S_BEQ (9): ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSrc=10. Next: S_FETCH.
- S_JMP (10): PCWrite=1, PCSrc=01. Next: S_FETCH.
- S_JAL (11): PCWrite=1, PCSrc=01, regwrite=1, regdst=10, memtoreg=10. Next: S_FETCH.
  - The register file captures the pre-jump PC (PC+4) on the same edge that the PC loads the target.
- S_ADDIEX (12): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: S_IMMWB.
- S_ANDIEX (13): ALUSrcA=1, ALUSrcB=10, ALUOp=11. Next: S_IMMWB.
- S_IMMWB (14): regwrite=1 (regdst=00, memtoreg=00). Next: S_FETCH.
- S_HALT (15): all outputs 0. Self-loop until rst.
- CPI: lw 5; sw, R-type, addi, andi 4; beq, j, jal 3.
- opcode is sampled only in S_DECODE and S_MEMADR. IR is stable then because IRWrite=1 only in S_FETCH.
- Reset mid-instruction: state returns to S_RST immediately, asynchronously. Any in-flight write strobe drops in the same cycle.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Extra output port illegal_op (1 bit, reset 0).
  - An unknown opcode in S_DECODE goes to S_HALT and sets illegal_op=1, sticky until rst.
- Undefined:
  - Port is absent; S_HALT is unreachable.
  - An unknown opcode in S_DECODE goes to S_FETCH, so the instruction executes as a 2-cycle no-op.

Decomposition:
- Package multicycle_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI, OP_ANDI)
  - ALUOp codes
  - state_t 4-bit enum with the codes above
- Single module with a state register plus next-state and output decoders. No sub-module is natural.

Test Plan:
- rst=1 then released; opcode=000000 -> all outputs 0 in the S_RST cycle; next cycle S_FETCH with memread=IRWrite=PCWrite=1 and ALUSrcB=01.
- opcode=100011 (lw) -> state_o sequence 1,2,3,4,5,1; regwrite=1 with memtoreg=01 only in cycle 5; exactly 5 cycles.
- opcode=101011 (sw) -> sequence 1,2,3,6,1; memwrite=1 with IorD=1 for exactly one cycle; regwrite is never 1.
- opcode=000011 (jal) -> S_JAL has PCWrite=1, PCSrc=01, regwrite=1, regdst=10, memtoreg=10; back to S_FETCH after 3 cycles.
- opcode=001100 (andi) -> S_ANDIEX drives ALUOp=11 and ALUSrcB=10; then S_IMMWB with regwrite=1 and regdst=00.
- opcode=111111 -> without macro, returns to S_FETCH after S_DECODE. With CTRL_ILLEGAL_TRAP_EN, state_o=15 and illegal_op=1 held; asserting rst mid-state clears both asynchronously.
